// File: rtl/transaction_controller_if.sv
// Control/data bundle between the transaction sequencer and the coin datapath.
interface transaction_controller_if;
  logic [2:0]  dp_process;
  logic        dp_player;
  logic [7:0]  dp_amount;
  logic [7:0]  dp_key;
  logic        load_player;
  logic        load_amount;
  logic        load_key;
  logic        load_register;
  logic        done_step;
  logic [47:0] dp_result;

  modport master (
    output dp_process, dp_player, dp_amount, dp_key,
    output load_player, load_amount, load_key, load_register,
    input  done_step, dp_result
  );

  modport slave (
    input  dp_process, dp_player, dp_amount, dp_key,
    input  load_player, load_amount, load_key, load_register,
    output done_step, dp_result
  );
endinterface

// File: rtl/transaction_controller.sv
// Sequencer for the coin datapath: load operands, step process codes 1..NUM_STEPS
// with a per-step timeout, then commit and latch the datapath result.
module transaction_controller #(
  parameter int NUM_STEPS = 5,
  parameter int TIMEOUT   = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        player_sel,
  input  logic [7:0]  amount,
  input  logic [7:0]  key,
  transaction_controller_if.master dp,
  output logic        busy,
  output logic        done,
  output logic [1:0]  error_code,
  output logic [2:0]  step_index,
  output logic [47:0] result
);

  typedef enum logic [2:0] {
    IDLE, LOAD, ISSUE, WAIT, COMMIT, DONE, FAIL
  } state_e;

  localparam logic [2:0] LAST_STEP = 3'(NUM_STEPS);
  localparam logic [7:0] TMR_LAST  = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        player_q, player_d;
  logic [7:0]  amount_q, amount_d;
  logic [7:0]  key_q, key_d;
  logic [2:0]  step_q, step_d;
  logic [7:0]  timer_q, timer_d;
  logic [1:0]  err_q, err_d;
  logic [47:0] result_q, result_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      player_q <= 1'b0;
      amount_q <= '0;
      key_q    <= '0;
      step_q   <= '0;
      timer_q  <= '0;
      err_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      player_q <= player_d;
      amount_q <= amount_d;
      key_q    <= key_d;
      step_q   <= step_d;
      timer_q  <= timer_d;
      err_q    <= err_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    player_d = player_q;
    amount_d = amount_q;
    key_d    = key_q;
    step_d   = step_q;
    timer_d  = timer_q;
    err_d    = err_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          player_d = player_sel;
          amount_d = amount;
          key_d    = key;
          // A zero transfer is rejected before the datapath sees anything.
          if (amount != 8'd0) begin
            err_d   = 2'b00;
            state_d = LOAD;
          end else begin
            err_d   = 2'b01;
            state_d = FAIL;
          end
        end
      end
      LOAD: begin
        step_d  = 3'd1;
        state_d = ISSUE;
      end
      ISSUE: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // done_step outranks the timeout when both land in the same cycle.
        if (dp.done_step) begin
          if (step_q == LAST_STEP) begin
            state_d = COMMIT;
          end else begin
            step_d  = step_q + 3'd1;
            state_d = ISSUE;
          end
        end else if (timer_q == TMR_LAST) begin
          err_d   = 2'b10;
          state_d = FAIL;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      COMMIT: begin
        result_d = dp.dp_result;
        state_d  = DONE;
      end
      DONE:    state_d = IDLE;
      FAIL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  logic in_step;
  assign in_step = (state_q == ISSUE) || (state_q == WAIT);

  assign dp.dp_process    = in_step ? step_q : 3'd0;
  assign dp.dp_player     = player_q;
  assign dp.dp_amount     = amount_q;
  assign dp.dp_key        = key_q;
  assign dp.load_player   = (state_q == LOAD);
  assign dp.load_amount   = (state_q == LOAD);
  assign dp.load_key      = (state_q == LOAD);
  assign dp.load_register = (state_q == COMMIT);

  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE) || (state_q == FAIL);
  assign error_code = err_q;
  assign step_index = in_step ? step_q : 3'd0;
  assign result     = result_q;

endmodule

// File: tb/tb_transaction_controller.sv
// Randomized scoreboard bench: a transaction-level model predicts strobe/done timing,
// error code and result; a monitor compares every cycle against the queue head.
module tb_transaction_controller;
  localparam int NS = 5;
  localparam int TO = 12;

  logic        clock = 1'b0;
  logic        reset, start, player_sel;
  logic [7:0]  amount, key;
  logic        busy, done;
  logic [1:0]  error_code;
  logic [2:0]  step_index;
  logic [47:0] result;

  transaction_controller_if dif();

  transaction_controller #(.NUM_STEPS(NS), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .start(start), .player_sel(player_sel),
    .amount(amount), .key(key), .dp(dif), .busy(busy), .done(done),
    .error_code(error_code), .step_index(step_index), .result(result)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int          t_start, t_load, t_commit, t_done, end_steps;
    int          issue [0:8];
    logic [1:0]  err;
    logic [47:0] res;
    logic        pl;
    logic [7:0]  am, ky;
  } exp_t;

  exp_t        q[$];
  int          dly [0:7];
  bit          ds_hold = 1'b0;
  bit          mon_en  = 1'b0;
  logic [47:0] prev_res = '0;
  logic [1:0]  last_err = '0;
  logic [47:0] last_res = '0;
  int          n_chk = 0, n_pass = 0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endfunction

  // Each step costs one ISSUE cycle plus (delay+1) WAIT cycles; a delay of TO or
  // more means the datapath never answers in time.
  function automatic exp_t model(int t, logic pl, logic [7:0] am, logic [7:0] ky);
    exp_t e;
    int   tt;
    e.t_start = t; e.pl = pl; e.am = am; e.ky = ky;
    e.t_load = -1; e.t_commit = -1; e.end_steps = -1;
    for (int k = 0; k <= 8; k++) e.issue[k] = -1;
    e.res = prev_res;
    if (am == 8'd0) begin
      e.t_done = t + 1; e.err = 2'b01;
      return e;
    end
    e.t_load = t + 1;
    tt = t + 2;
    for (int k = 1; k <= NS; k++) begin
      e.issue[k] = tt;
      if (dly[k] >= TO) begin
        e.t_done = tt + 1 + TO; e.end_steps = e.t_done; e.err = 2'b10;
        return e;
      end
      tt += 2 + dly[k];
    end
    e.end_steps = tt; e.t_commit = tt; e.t_done = tt + 1; e.err = 2'b00;
    e.res = {16'hC0DE, 32'(tt)};
    return e;
  endfunction

  function automatic int exp_proc(exp_t e, int c);
    int nxt;
    for (int k = 1; k <= NS; k++) begin
      if (e.issue[k] >= 0 && c >= e.issue[k]) begin
        nxt = (k < NS && e.issue[k+1] >= 0) ? e.issue[k+1] : e.end_steps;
        if (c < nxt) return k;
      end
    end
    return 0;
  endfunction

  task automatic step();
    @(negedge clock); #1;
  endtask

  // Datapath stand-in: answers step k on WAIT cycle dly[k]; done_step is noise elsewhere.
  initial begin
    logic [2:0] p, prev_p;
    int         wcnt;
    prev_p = '0; wcnt = 0;
    dif.done_step = 1'b0; dif.dp_result = '0;
    forever begin
      @(negedge clock); #1;
      p = dif.dp_process;
      dif.dp_result = {16'hC0DE, 32'(cyc)};
      if (p != 3'd0 && p == prev_p) begin
        dif.done_step = (wcnt == dly[p]);
        wcnt++;
      end else begin
        wcnt = 0;
        dif.done_step = ds_hold ? 1'b1 : 1'($urandom_range(0, 1));
      end
      prev_p = p;
    end
  end

  initial begin
    exp_t f;
    bit   has;
    int   ep;
    forever begin
      @(negedge clock);
      if (mon_en) begin
        has = q.size() > 0;
        if (has && cyc > q[0].t_done) begin
          chk("done_missing", 64'(cyc), 64'(q[0].t_done));
          void'(q.pop_front());
          has = q.size() > 0;
        end
        if (has) f = q[0];
        ep = has ? exp_proc(f, cyc) : 0;
        chk("busy", 64'(busy), has ? 64'(cyc > f.t_start) : 64'd0);
        chk("dp_process", 64'(dif.dp_process), 64'(ep));
        chk("step_index", 64'(step_index), 64'(ep));
        if (dif.load_player | dif.load_amount | dif.load_key) begin
          chk("load_cycle", 64'(cyc), has ? 64'(f.t_load) : -64'sd1);
          if (has)
            chk("load_ops", {dif.load_player, dif.load_amount, dif.load_key, dif.dp_player,
                             dif.dp_amount, dif.dp_key}, {3'b111, f.pl, f.am, f.ky});
        end
        if (dif.load_register)
          chk("commit_cycle", 64'(cyc), has ? 64'(f.t_commit) : -64'sd1);
        if (done) begin
          chk("done_cycle", 64'(cyc), has ? 64'(f.t_done) : -64'sd1);
          if (has) begin
            chk("error_code", 64'(error_code), 64'(f.err));
            chk("result", result, f.res);
            chk("captured_ops", {dif.dp_player, dif.dp_amount, dif.dp_key}, {f.pl, f.am, f.ky});
            last_err = f.err; last_res = f.res;
            void'(q.pop_front());
          end
        end else if (!has) begin
          chk("idle_error_hold", 64'(error_code), 64'(last_err));
          chk("idle_result_hold", result, last_res);
        end
      end
    end
  end

  task automatic check_reset_state();
    chk("reset_result", result, 48'd0);
    chk("reset_ctrl", {busy, done, error_code, step_index, dif.dp_process, dif.dp_player,
                       dif.dp_amount, dif.dp_key, dif.load_player, dif.load_amount,
                       dif.load_key, dif.load_register}, 64'd0);
  endtask

  task automatic do_txn(input logic pl, input logic [7:0] am, input logic [7:0] ky,
                        input bit noise, input int rst_off);
    exp_t e;
    e = model(cyc, pl, am, ky);
    q.push_back(e);
    prev_res = e.res;
    start = 1'b1; player_sel = pl; amount = am; key = ky;
    step();
    while (cyc <= e.t_done) begin
      if (rst_off > 0 && cyc == e.t_start + rst_off) begin
        reset = 1'b1; start = 1'b0;
        q.delete();
        prev_res = '0; last_err = '0; last_res = '0;
        step();
        check_reset_state();
        reset = 1'b0;
        return;
      end
      start = noise && ($urandom_range(0, 2) == 0);
      player_sel = 1'($urandom); amount = 8'($urandom); key = 8'($urandom);
      step();
    end
    start = 1'b0;
  endtask

  task automatic clr_dly();
    for (int k = 0; k < 8; k++) dly[k] = 0;
  endtask

  task automatic rnd_dly();
    int r;
    for (int k = 0; k < 8; k++) begin
      r = $urandom_range(0, 19);
      if (r < 14)      dly[k] = r % 4;
      else if (r < 17) dly[k] = TO - 1;
      else if (r < 18) dly[k] = TO;
      else             dly[k] = $urandom_range(4, 9);
    end
  endtask

  initial begin
    repeat (60000) @(posedge clock);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; player_sel = 1'b0; amount = '0; key = '0;
    clr_dly();
    repeat (3) step();
    check_reset_state();
    reset = 1'b0;
    mon_en = 1'b1;
    step();

    ds_hold = 1'b1;
    do_txn(1'b1, 8'h05, 8'hA3, 1'b0, 0);
    ds_hold = 1'b0;
    step();
    clr_dly(); dly[3] = 10;
    do_txn(1'b0, 8'h3C, 8'h11, 1'b0, 0);
    clr_dly(); dly[1] = TO;
    do_txn(1'b1, 8'h77, 8'h5A, 1'b0, 0);
    clr_dly(); dly[2] = TO - 1;
    do_txn(1'b0, 8'hFF, 8'h00, 1'b0, 0);
    clr_dly();
    do_txn(1'b1, 8'h00, 8'hEE, 1'b0, 0);
    do_txn(1'b0, 8'h21, 8'h42, 1'b1, 0);
    clr_dly(); dly[2] = 5;
    do_txn(1'b1, 8'h09, 8'h99, 1'b0, 6);
    clr_dly();
    do_txn(1'b0, 8'h12, 8'h34, 1'b1, 0);

    for (int i = 0; i < 40; i++) begin
      logic [7:0] am;
      rnd_dly();
      am = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      do_txn(1'($urandom), am, 8'($urandom), 1'($urandom),
             ($urandom_range(0, 19) == 0) ? $urandom_range(1, 12) : 0);
      repeat ($urandom_range(0, 2)) step();
    end

    repeat (4) step();
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
